// File: rtl/msm_fifo_fwft_1r1w_if.sv
// msm_fifo_fwft_1r1w_if
//   Stream bundle for the MSM first-word-fall-through FIFO.
//   Upstream side : i_valid, i_ready, i_data
//   Downstream side: o_valid, o_ready, o_data
//   Status        : count, afull, empty
//   slave  : the FIFO's view (drives i_ready, o_*, status).
//   master : the surrounding logic's view (drives i_valid, i_data, o_ready).
interface msm_fifo_fwft_1r1w_if #(
    parameter int WIDTH  = 64,
    parameter int ADDRSZ = 9
);
    logic              i_valid;
    logic              i_ready;
    logic [WIDTH-1:0]  i_data;
    logic              o_valid;
    logic              o_ready;
    logic [WIDTH-1:0]  o_data;
    logic [ADDRSZ+1:0] count;
    logic              afull;
    logic              empty;

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, count, afull, empty
    );

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, count, afull, empty
    );
endinterface

// File: rtl/msm_fifo_fwft_1r1w.sv
// ram_mdl_1r1w
//   Simple dual-port RAM model, one write port and one registered read port.
//   wclk/we/waddr/wdata : write port, WESZ lane enables over WIDTH bits
//   rclk/re/raddr/rdata : read port, rdata valid the cycle after re
module ram_mdl_1r1w #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 64,
    parameter int ADDRSZ = 9,
    parameter int WESZ   = 1,
    parameter     RAM_STYLE = "block"
) (
    input  logic              wclk,
    input  logic [WESZ-1:0]   we,
    input  logic [ADDRSZ-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rclk,
    input  logic              re,
    input  logic [ADDRSZ-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int LANE = WIDTH / WESZ;

    if ((WIDTH % WESZ) != 0) begin : g_bad_wesz
        $fatal(1, "ram_mdl_1r1w: WIDTH must be a multiple of WESZ");
    end
    if (RAM_STYLE != "block" && RAM_STYLE != "distributed" &&
        RAM_STYLE != "ultra" && RAM_STYLE != "auto") begin : g_bad_style
        $fatal(1, "ram_mdl_1r1w: unsupported RAM_STYLE");
    end

    (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wclk) begin
        for (int unsigned l = 0; l < WESZ; l++) begin
            if (we[l]) begin
                mem[waddr][l*LANE +: LANE] <= wdata[l*LANE +: LANE];
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// msm_fifo_fwft_1r1w
//   First-word-fall-through FIFO around one ram_mdl_1r1w, with a 2-entry
//   output skid (head + spare) that hides the RAM read latency.
//   clk  : sole clock
//   rstN : synchronous reset, active low
//   bus  : slave modport -- i_valid/i_ready/i_data in, o_valid/o_ready/o_data
//          out, count (words held), afull (count >= AFULL_TH), empty.
module msm_fifo_fwft_1r1w #(
    parameter int DEPTH     = 512,
    parameter int WIDTH     = 64,
    parameter int ADDRSZ    = 9,
    parameter     RAM_STYLE = "block",
    parameter int AFULL_TH  = 504
) (
    input  logic                  clk,
    input  logic                  rstN,
    msm_fifo_fwft_1r1w_if.slave   bus
);
    localparam int CW = ADDRSZ + 2;

    if (DEPTH != (1 << ADDRSZ)) begin : g_bad_depth
        $fatal(1, "msm_fifo_fwft_1r1w: DEPTH must equal 2**ADDRSZ");
    end

    logic [ADDRSZ-1:0] wptr_q, wptr_d;
    logic [ADDRSZ-1:0] rptr_q, rptr_d;
    logic [ADDRSZ:0]   ram_cnt_q, ram_cnt_d;
    logic              inflight_q, inflight_d;
    logic              head_vld_q, head_vld_d;
    logic              spare_vld_q, spare_vld_d;
    logic [WIDTH-1:0]  head_q, head_d;
    logic [WIDTH-1:0]  spare_q, spare_d;
    logic [CW-1:0]     count_q, count_d;
    logic              i_ready_q, i_ready_d;
    logic              afull_q, afull_d;

    logic              push, pop, re;
    logic [2:0]        occ_after;
    logic [WIDTH-1:0]  rdata;

    assign push = bus.i_valid && i_ready_q;
    assign pop  = head_vld_q && bus.o_ready;

    // Skid slots that will still be spoken for after this edge, counting the
    // word already in flight from the RAM; only issue a read if one is left.
    assign occ_after = 3'(head_vld_q) + 3'(spare_vld_q) + 3'(inflight_q) - 3'(pop);
    assign re        = (ram_cnt_q != '0) && (occ_after < 3'd2);

    ram_mdl_1r1w #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .ADDRSZ    (ADDRSZ),
        .WESZ      (1),
        .RAM_STYLE (RAM_STYLE)
    ) u_ram (
        .wclk  (clk),
        .we    (push),
        .waddr (wptr_q),
        .wdata (bus.i_data),
        .rclk  (clk),
        .re    (re),
        .raddr (rptr_q),
        .rdata (rdata)
    );

    always_comb begin
        wptr_d      = wptr_q + ADDRSZ'(push);
        rptr_d      = rptr_q + ADDRSZ'(re);
        ram_cnt_d   = ram_cnt_q + (ADDRSZ+1)'(push) - (ADDRSZ+1)'(re);
        inflight_d  = re;
        count_d     = count_q + CW'(push) - CW'(pop);
        i_ready_d   = ram_cnt_d < (ADDRSZ+1)'(DEPTH);
        afull_d     = count_d >= CW'(AFULL_TH);

        head_vld_d  = head_vld_q;
        head_d      = head_q;
        spare_vld_d = spare_vld_q;
        spare_d     = spare_q;

        // Pop first (spare slides into head), then the arriving RAM word
        // fills whichever slot is free afterwards, head preferred.
        if (pop) begin
            if (spare_vld_q) begin
                head_d      = spare_q;
                spare_vld_d = 1'b0;
            end else begin
                head_vld_d  = 1'b0;
            end
        end
        if (inflight_q) begin
            if (!head_vld_d) begin
                head_d      = rdata;
                head_vld_d  = 1'b1;
            end else begin
                spare_d     = rdata;
                spare_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            ram_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            head_vld_q  <= 1'b0;
            spare_vld_q <= 1'b0;
            head_q      <= '0;
            spare_q     <= '0;
            count_q     <= '0;
            i_ready_q   <= 1'b0;
            afull_q     <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ram_cnt_q   <= ram_cnt_d;
            inflight_q  <= inflight_d;
            head_vld_q  <= head_vld_d;
            spare_vld_q <= spare_vld_d;
            head_q      <= head_d;
            spare_q     <= spare_d;
            count_q     <= count_d;
            i_ready_q   <= i_ready_d;
            afull_q     <= afull_d;
        end
    end

    assign bus.i_ready = i_ready_q;
    assign bus.o_valid = head_vld_q;
    assign bus.o_data  = head_q;
    assign bus.count   = count_q;
    assign bus.afull   = afull_q;
    assign bus.empty   = (count_q == '0);
endmodule

// File: tb/tb_msm_fifo_fwft_1r1w.sv
module tb_msm_fifo_fwft_1r1w;
    localparam int WIDTH    = 64;
    localparam int ADDRSZ   = 9;
    localparam int DEPTH    = 512;
    localparam int AFULL_TH = 504;
    localparam int CW       = ADDRSZ + 2;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    always #5 clk = ~clk;

    msm_fifo_fwft_1r1w_if #(.WIDTH(WIDTH), .ADDRSZ(ADDRSZ)) bus ();

    msm_fifo_fwft_1r1w #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .ADDRSZ    (ADDRSZ),
        .RAM_STYLE ("block"),
        .AFULL_TH  (AFULL_TH)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] exp_q [$];
    int               cnt_m  = 0;
    int               pushes = 0;
    int               pops   = 0;
    logic             mon_en = 1'b0;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] stall_data = '0;
    logic [WIDTH-1:0] last_pop   = '0;

    // Edge monitor: scoreboard push on accept, pop/compare on delivery,
    // and stall stability of o_data.
    always @(posedge clk) begin
        if (mon_en) begin
            if (!rstN) begin
                exp_q.delete();
                cnt_m      = 0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    vectors++;
                    if (bus.o_valid !== 1'b1 || bus.o_data !== stall_data) begin
                        miscompares++;
                        $display("FAIL stall_hold: o_valid=%b o_data=%h required o_valid=1 o_data=%h",
                                 bus.o_valid, bus.o_data, stall_data);
                    end
                end
                if (bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL pop_underflow: o_data=%h required no delivery", bus.o_data);
                    end else begin
                        logic [WIDTH-1:0] e;
                        e = exp_q.pop_front();
                        if (bus.o_data !== e) begin
                            miscompares++;
                            $display("FAIL pop_data: o_data=%h required %h", bus.o_data, e);
                        end
                    end
                    pops++;
                    last_pop = bus.o_data;
                    cnt_m--;
                end
                if (bus.i_valid === 1'b1 && bus.i_ready === 1'b1) begin
                    exp_q.push_back(bus.i_data);
                    pushes++;
                    cnt_m++;
                end
                stall_prev = (bus.o_valid === 1'b1) && (bus.o_ready !== 1'b1);
                stall_data = bus.o_data;
            end
        end
    end

    // Status check every cycle against the count model.
    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (bus.count !== CW'(cnt_m) || bus.afull !== (cnt_m >= AFULL_TH) ||
                bus.empty !== (cnt_m == 0)) begin
                miscompares++;
                $display("FAIL status: count=%0d afull=%b empty=%b required count=%0d afull=%b empty=%b",
                         bus.count, bus.afull, bus.empty, cnt_m, cnt_m >= AFULL_TH, cnt_m == 0);
            end
        end
    end

    task automatic test_reset();
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.o_ready = 1'b0;
        rstN        = 1'b0;
        mon_en      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.i_ready !== 1'b0 || bus.o_valid !== 1'b0 || bus.afull !== 1'b0 ||
            bus.empty !== 1'b1 || bus.o_data !== '0 || bus.count !== '0) begin
            miscompares++;
            $display("FAIL reset_state: i_ready=%b o_valid=%b afull=%b empty=%b o_data=%h count=%0d required 0 0 0 1 0 0",
                     bus.i_ready, bus.o_valid, bus.afull, bus.empty, bus.o_data, bus.count);
        end
        rstN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.i_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: i_ready=%b required 1", bus.i_ready);
        end
    endtask

    task automatic test_single();
        int p0;
        p0 = pops;
        bus.i_valid = 1'b1;
        bus.i_data  = 64'hA5;
        bus.o_ready = 1'b1;
        @(posedge clk);                       // E0
        @(negedge clk);
        bus.i_valid = 1'b0;
        vectors++;
        if (bus.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_e0: o_valid=%b required 0", bus.o_valid);
        end
        @(posedge clk);                       // E1
        @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_e1: o_valid=%b required 0", bus.o_valid);
        end
        @(posedge clk);                       // E2
        @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 64'hA5) begin
            miscompares++;
            $display("FAIL single_e2: o_valid=%b o_data=%h required 1 a5", bus.o_valid, bus.o_data);
        end
        @(posedge clk);                       // E3
        @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.empty !== 1'b1 || bus.count !== '0 || pops - p0 != 1) begin
            miscompares++;
            $display("FAIL single_e3: o_valid=%b empty=%b count=%0d pops=%0d required 0 1 0 1",
                     bus.o_valid, bus.empty, bus.count, pops - p0);
        end
    endtask

    task automatic test_fill();
        int acc;
        int p0;
        logic will;
        acc = 0;
        p0  = pops;
        bus.o_ready = 1'b0;
        bus.i_valid = 1'b1;
        for (int c = 0; c < 700; c++) begin
            bus.i_data = WIDTH'(acc);
            will = bus.i_ready;
            @(posedge clk);
            @(negedge clk);
            if (will) acc++;
        end
        bus.i_valid = 1'b0;
        vectors++;
        if (acc != DEPTH + 2 || bus.i_ready !== 1'b0 || bus.count !== CW'(DEPTH + 2) ||
            bus.afull !== 1'b1 || bus.o_valid !== 1'b1 || bus.o_data !== '0) begin
            miscompares++;
            $display("FAIL fill_full: accepted=%0d i_ready=%b count=%0d afull=%b o_valid=%b o_data=%h required 514 0 514 1 1 0",
                     acc, bus.i_ready, bus.count, bus.afull, bus.o_valid, bus.o_data);
        end
        bus.o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.i_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_ready_return: i_ready=%b required 1", bus.i_ready);
        end
        for (int c = 0; c < 1000 && bus.empty !== 1'b1; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        vectors++;
        if (pops - p0 != DEPTH + 2 || bus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_drain: delivered=%0d empty=%b required 514 1", pops - p0, bus.empty);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int p0;
        int bubbles;
        logic seen;
        logic will;
        n = 0; p0 = pops; bubbles = 0; seen = 1'b0;
        bus.o_ready = 1'b1;
        for (int c = 0; c < 2300 && (pops - p0) < 2000; c++) begin
            bus.i_valid = (n < 2000);
            bus.i_data  = WIDTH'(n);
            will = bus.i_valid && bus.i_ready;
            @(posedge clk);
            @(negedge clk);
            if (will) n++;
            if (bus.o_valid === 1'b1) seen = 1'b1;
            else if (seen && (pops - p0) < 2000) bubbles++;
        end
        bus.i_valid = 1'b0;
        vectors++;
        if (n != 2000 || pops - p0 != 2000 || bubbles != 0) begin
            miscompares++;
            $display("FAIL stream: pushed=%0d delivered=%0d bubbles=%0d required 2000 2000 0",
                     n, pops - p0, bubbles);
        end
    endtask

    task automatic test_random();
        int n;
        int p0;
        logic will;
        n = 0; p0 = pops;
        for (int c = 0; c < 60000 && (pops - p0) < 10000; c++) begin
            bus.i_valid = (n < 10000) && ($urandom_range(0, 1) == 1);
            bus.i_data  = {$urandom, $urandom};
            bus.o_ready = ($urandom_range(0, 1) == 1);
            will = bus.i_valid && bus.i_ready;
            @(posedge clk);
            @(negedge clk);
            if (will) n++;
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        vectors++;
        if (n != 10000 || pops - p0 != 10000) begin
            miscompares++;
            $display("FAIL random: pushed=%0d delivered=%0d required 10000 10000", n, pops - p0);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int p0;
        logic will;
        n = 0; p0 = pops;
        bus.o_ready = 1'b0;
        for (int c = 0; c < 50 && n < 10; c++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = WIDTH'(32'h100 + n);
            will = bus.i_ready;
            @(posedge clk);
            @(negedge clk);
            if (will) n++;
        end
        bus.i_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 100 && (pops - p0) < 10; c++) begin
            bus.o_ready = (c % 2 == 0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.o_ready = 1'b1;
        vectors++;
        if (n != 10 || pops - p0 != 10 || last_pop !== WIDTH'(32'h109)) begin
            miscompares++;
            $display("FAIL backpressure: pushed=%0d delivered=%0d last=%h required 10 10 109",
                     n, pops - p0, last_pop);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int p0;
        logic will;
        n = 0;
        bus.o_ready = 1'b0;
        for (int c = 0; c < 400 && n < 300; c++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = WIDTH'(32'h5000 + n);
            will = bus.i_ready;
            @(posedge clk);
            @(negedge clk);
            if (will) n++;
        end
        bus.i_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b1 || bus.count !== CW'(300)) begin
            miscompares++;
            $display("FAIL mid_loaded: o_valid=%b count=%0d required 1 300", bus.o_valid, bus.count);
        end
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.count !== '0 || bus.empty !== 1'b1 || bus.i_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: o_valid=%b count=%0d empty=%b i_ready=%b required 0 0 1 0",
                     bus.o_valid, bus.count, bus.empty, bus.i_ready);
        end
        rstN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.i_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_release: i_ready=%b o_valid=%b required 1 0", bus.i_ready, bus.o_valid);
        end
        p0 = pops;
        bus.o_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 64'h77;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        for (int c = 0; c < 10 && pops == p0; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        vectors++;
        if (pops - p0 != 1 || last_pop !== 64'h77) begin
            miscompares++;
            $display("FAIL mid_next_word: delivered=%0d data=%h required 1 77", pops - p0, last_pop);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_random();
        test_backpressure();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
